// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one fetch in flight and buffers returned
// words in a small prefetch FIFO that feeds the IF/ID pipeline register.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        IF_ID_en,
  input  logic        Branch_taken,
  input  logic [31:0] Branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] PCAddress,
  output logic [31:0] Instruction,
  output logic        Fetch_valid,
  output logic        IF_Flush
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;

  typedef enum logic {ST_RUN, ST_DRAIN} state_t;

  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        req_addr_q, req_addr_d;
  logic               pending_q, pending_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [31:0]        fifo_addr4_q [FIFO_DEPTH];
  logic [31:0]        fifo_addr4_d [FIFO_DEPTH];
  logic [31:0]        fifo_word_q  [FIFO_DEPTH];
  logic [31:0]        fifo_word_d  [FIFO_DEPTH];

  logic               head_valid;
  logic               pop;
  logic               push;
  logic               issue;
  logic [OCC_W-1:0]   occ_after;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Issue only if the slot the new word will need is guaranteed free on arrival.
  always_comb begin
    head_valid = (count_q != '0);
    pop        = IF_ID_en & head_valid;
    occ_after  = OCC_W'(count_q) + OCC_W'(pending_q) - OCC_W'(pop);
    issue      = !Rst && (state_q == ST_RUN) && !Branch_taken
                 && (!pending_q || imem_valid) && (occ_after < OCC_W'(FIFO_DEPTH));
    push       = (state_q == ST_RUN) && pending_q && imem_valid && !Branch_taken;
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    pending_d    = pending_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    fifo_addr4_d = fifo_addr4_q;
    fifo_word_d  = fifo_word_q;

    if (Branch_taken) begin
      pc_d     = Branch_target & ~32'd3;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      // An unanswered request must be drained so its word is never buffered.
      if (pending_q && !imem_valid) begin
        state_d = ST_DRAIN;
      end else begin
        pending_d = 1'b0;
        state_d   = ST_RUN;
      end
    end else if (state_q == ST_DRAIN) begin
      if (imem_valid) begin
        pending_d = 1'b0;
        state_d   = ST_RUN;
      end
    end else begin
      if (push) begin
        fifo_addr4_d[wr_ptr_q] = req_addr_q + 32'd4;
        fifo_word_d[wr_ptr_q]  = imem_rdata;
        wr_ptr_d               = ptr_inc(wr_ptr_q);
        pending_d              = 1'b0;
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
      if (issue) begin
        pc_d       = pc_q + 32'd4;
        req_addr_d = pc_q;
        pending_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      pending_q  <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_addr4_q[i] <= '0;
        fifo_word_q[i]  <= '0;
      end
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      pending_q    <= pending_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      fifo_addr4_q <= fifo_addr4_d;
      fifo_word_q  <= fifo_word_d;
    end
  end

  // An empty FIFO presents a NOP bubble tagged with the current PC.
  assign imem_req    = issue;
  assign imem_addr   = pc_q;
  assign Fetch_valid = head_valid;
  assign PCAddress   = head_valid ? fifo_addr4_q[rd_ptr_q] : pc_q;
  assign Instruction = head_valid ? fifo_word_q[rd_ptr_q] : 32'h0;
  assign IF_Flush    = Branch_taken;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a programmable-latency memory model plus a scoreboard
// that checks every consumed instruction follows the previous one in address order.
module tb_if_fetch_unit;

  logic        Clk;
  logic        Rst;
  logic        IF_ID_en;
  logic        Branch_taken;
  logic [31:0] Branch_target;
  logic        imem_req, imem_req2;
  logic [31:0] imem_addr, imem_addr2;
  logic [31:0] imem_rdata, imem_rdata2;
  logic        imem_valid, imem_valid2;
  logic [31:0] PCAddress, PCAddress2;
  logic [31:0] Instruction, Instruction2;
  logic        Fetch_valid, Fetch_valid2;
  logic        IF_Flush, IF_Flush2;

  if_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .Clk(Clk), .Rst(Rst), .IF_ID_en(IF_ID_en), .Branch_taken(Branch_taken),
    .Branch_target(Branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid), .PCAddress(PCAddress),
    .Instruction(Instruction), .Fetch_valid(Fetch_valid), .IF_Flush(IF_Flush)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_wrap (
    .Clk(Clk), .Rst(Rst), .IF_ID_en(IF_ID_en), .Branch_taken(Branch_taken),
    .Branch_target(Branch_target), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_rdata(imem_rdata2), .imem_valid(imem_valid2), .PCAddress(PCAddress2),
    .Instruction(Instruction2), .Fetch_valid(Fetch_valid2), .IF_Flush(IF_Flush2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int          n_checks = 0;
  int          n_errors = 0;

  int          lat = 1;
  bit          mem_busy;
  int          mem_wait;
  logic [31:0] mem_addr;
  bit          stray;
  bit          m2_req;
  logic [31:0] m2_addr;
  logic [31:0] sb_next;

  logic        o_req, o_fv, o_flush;
  logic [31:0] o_addr, o_pca, o_instr, o_addr2, o_pca2;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle, entered and left just after a falling edge.
  task automatic tick();
    if (stray) begin
      imem_valid = 1'b1;
      imem_rdata = 32'hBAD0_BAD0;
      stray      = 1'b0;
    end else if (mem_busy && mem_wait == 0) begin
      imem_valid = 1'b1;
      imem_rdata = word_of(mem_addr);
      mem_busy   = 1'b0;
    end else begin
      imem_valid = 1'b0;
      imem_rdata = 32'h0;
      if (mem_busy) mem_wait--;
    end
    imem_valid2 = m2_req;
    imem_rdata2 = word_of(m2_addr);
    #1;
    o_req   = imem_req;
    o_addr  = imem_addr;
    o_pca   = PCAddress;
    o_instr = Instruction;
    o_fv    = Fetch_valid;
    o_flush = IF_Flush;
    o_addr2 = imem_addr2;
    o_pca2  = PCAddress2;
    if (imem_req) begin
      mem_busy = 1'b1;
      mem_addr = imem_addr;
      mem_wait = lat - 1;
    end
    m2_req  = imem_req2;
    m2_addr = imem_addr2;
    if (Fetch_valid && IF_ID_en && !Branch_taken) begin
      check("sb_pca", PCAddress, sb_next);
      check("sb_instr", Instruction, word_of(sb_next - 32'd4));
      sb_next = sb_next + 32'd4;
    end
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic release_reset();
    @(negedge Clk);
    Rst      = 1'b0;
    mem_busy = 1'b0;
    m2_req   = 1'b0;
    sb_next  = 32'h4;
  endtask

  initial begin
    Rst = 1'b0; IF_ID_en = 1'b1; Branch_taken = 1'b1; Branch_target = 32'h0;
    imem_valid = 1'b0; imem_rdata = 32'h0; imem_valid2 = 1'b0; imem_rdata2 = 32'h0;
    mem_busy = 1'b0; stray = 1'b0; m2_req = 1'b0; m2_addr = 32'h0; sb_next = 32'h4;

    // Reset values, IF_Flush follows Branch_taken even in reset
    #2 Rst = 1'b1;
    #1;
    check("rst_req", 32'(imem_req), 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_fv", 32'(Fetch_valid), 32'h0);
    check("rst_instr", Instruction, 32'h0);
    check("rst_pca", PCAddress, 32'h0);
    check("rst_flush_hi", 32'(IF_Flush), 32'h1);
    check("rst_addr_wrap", imem_addr2, 32'hFFFF_FFF8);
    Branch_taken = 1'b0;
    #1;
    check("rst_flush_lo", 32'(IF_Flush), 32'h0);
    @(negedge Clk);
    release_reset();

    // Back-to-back fetch with 1-cycle memory; second instance wraps past 2^32
    for (int k = 0; k < 6; k++) begin
      tick();
      check("t1_req", 32'(o_req), 32'h1);
      check("t1_addr", o_addr, 32'(4 * k));
      check("t5_addr", o_addr2, 32'hFFFF_FFF8 + 32'(4 * k));
      if (k >= 2) begin
        check("t1_fv", 32'(o_fv), 32'h1);
        check("t1_pca", o_pca, 32'(4 * (k - 1)));
        check("t1_instr", o_instr, word_of(32'(4 * (k - 2))));
        check("t5_pca", o_pca2, 32'hFFFF_FFF8 + 32'(4 * (k - 1)));
      end else begin
        check("t1_fv_empty", 32'(o_fv), 32'h0);
        check("t1_instr_nop", o_instr, 32'h0);
        check("t1_pca_pc", o_pca, 32'(4 * k));
      end
    end

    // Stall: FIFO fills, fetch stops, head held
    IF_ID_en = 1'b0;
    for (int s = 0; s < 5; s++) begin
      tick();
      check("t2_req_off", 32'(o_req), 32'h0);
      check("t2_fv", 32'(o_fv), 32'h1);
      check("t2_pca_hold", o_pca, 32'h14);
    end
    IF_ID_en = 1'b1;
    tick();
    check("t2_resume_req", 32'(o_req), 32'h1);
    check("t2_resume_addr", o_addr, 32'h18);
    for (int s = 0; s < 5; s++) tick();

    // Redirect while a slow fetch of 0x10 is outstanding
    Rst = 1'b1;
    release_reset();
    for (int k = 0; k < 4; k++) tick();
    lat = 3;
    tick();
    check("t3_addr10", o_addr, 32'h10);
    lat = 1;
    Branch_taken = 1'b1; Branch_target = 32'h103;
    tick();
    check("t3_flush", 32'(o_flush), 32'h1);
    check("t3_req_br", 32'(o_req), 32'h0);
    Branch_taken = 1'b0;
    sb_next = 32'h104;
    tick();
    check("t3_drain_req", 32'(o_req), 32'h0);
    check("t3_drain_fv", 32'(o_fv), 32'h0);
    check("t3_flush_lo", 32'(o_flush), 32'h0);
    tick();
    check("t3_discard_req", 32'(o_req), 32'h0);
    check("t3_discard_fv", 32'(o_fv), 32'h0);
    tick();
    check("t3_target_req", 32'(o_req), 32'h1);
    check("t3_target_addr", o_addr, 32'h100);
    tick();
    check("t3_fv_empty", 32'(o_fv), 32'h0);
    tick();
    check("t3_fv", 32'(o_fv), 32'h1);
    check("t3_pca", o_pca, 32'h104);
    for (int k = 0; k < 3; k++) tick();

    // Redirect in the same cycle as a response: no drain
    Branch_taken = 1'b1; Branch_target = 32'h202;
    tick();
    check("t4_flush", 32'(o_flush), 32'h1);
    check("t4_req_br", 32'(o_req), 32'h0);
    Branch_taken = 1'b0;
    sb_next = 32'h204;
    tick();
    check("t4_req", 32'(o_req), 32'h1);
    check("t4_addr", o_addr, 32'h200);
    check("t4_fv", 32'(o_fv), 32'h0);
    tick();
    check("t4_addr2", o_addr, 32'h204);
    tick();
    check("t4_pca", o_pca, 32'h204);
    check("t4_instr", o_instr, word_of(32'h200));

    // Reset with a fetch in flight and data buffered, then a stray response
    lat = 4; IF_ID_en = 1'b0;
    tick();
    tick();
    Rst = 1'b1;
    #1;
    check("t6_req", 32'(imem_req), 32'h0);
    check("t6_addr", imem_addr, 32'h0);
    check("t6_fv", 32'(Fetch_valid), 32'h0);
    check("t6_instr", Instruction, 32'h0);
    check("t6_pca", PCAddress, 32'h0);
    release_reset();
    lat = 1; IF_ID_en = 1'b1; stray = 1'b1;
    tick();
    check("t6_restart_req", 32'(o_req), 32'h1);
    check("t6_restart_addr", o_addr, 32'h0);
    tick();
    check("t6_stray_fv", 32'(o_fv), 32'h0);
    check("t6_stray_pca", o_pca, 32'h4);
    tick();
    check("t6_fv", 32'(o_fv), 32'h1);
    check("t6_instr", o_instr, word_of(32'h0));
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
